// File: rtl/mac_rx_fcs_ctrl.sv
// mac_rx_fcs_ctrl
//   Receive-side frame checker for a 32-bit MAC datapath. It steers incoming
//   words into an external CRC engine, counts frame length, and turns the
//   frame boundary plus the engine's registered sum into a one-cycle result
//   pulse carrying the good/bad verdict and the individual error causes.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   rx_valid_i          input word valid
//   rx_start_i          first word of frame (qualified by rx_valid_i)
//   rx_last_i           last word of frame (qualified by rx_valid_i)
//   rx_keep_i[3:0]      byte enables of the last word, LSB = byte 0
//   rx_data_i[31:0]     frame word, FCS included
//   rx_abort_i          PCS error / abort for the current frame
//   crc_start_o         CRC engine start (engine presets to zero)
//   crc_valid_o         CRC engine word valid
//   crc_data_o[31:0]    CRC engine data
//   crc_i[31:0]         registered CRC engine sum
//   busy_o              frame in progress
//   done_o              one-cycle frame-result pulse
//   ok_o                frame good, valid with done_o
//   fcs_err_o, len_err_o, align_err_o, abort_o
//                       error causes, valid with done_o
module mac_rx_fcs_ctrl #(
  parameter int          MIN_WORDS = 16,
  parameter int          MAX_WORDS = 380,
  parameter logic [31:0] RESIDUE   = 32'hC704DD7B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid_i,
  input  logic        rx_start_i,
  input  logic        rx_last_i,
  input  logic [3:0]  rx_keep_i,
  input  logic [31:0] rx_data_i,
  input  logic        rx_abort_i,
  output logic        crc_start_o,
  output logic        crc_valid_o,
  output logic [31:0] crc_data_o,
  input  logic [31:0] crc_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ok_o,
  output logic        fcs_err_o,
  output logic        len_err_o,
  output logic        align_err_o,
  output logic        abort_o
);

  localparam logic [9:0] MIN_W = 10'(MIN_WORDS);
  localparam logic [9:0] MAX_W = 10'(MAX_WORDS);
  localparam logic [9:0] SAT_W = 10'(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, DATA, CHECK, DROP} state_t;

  state_t     state_q, state_d;
  logic [8:0] word_cnt_q, word_cnt_d;
  logic       pend_len_q, pend_len_d;     // length verdict latched at last word
  logic       pend_align_q, pend_align_d; // keep verdict latched at last word
  logic       done_q, done_d;
  logic       ok_q, ok_d;
  logic       fcs_err_q, fcs_err_d;
  logic       len_err_q, len_err_d;
  logic       align_err_q, align_err_d;
  logic       abort_q, abort_d;

  logic       sow, eow, begin_frame;
  logic [9:0] cnt_inc;
  logic       len_bad_cur, len_bad_one;

  // CRC steering. The start word is inverted so a zero-preset engine behaves
  // as an all-ones-preset one. A start word always reaches the engine, even
  // in DROP, because it opens the next frame.
  assign crc_start_o = rx_valid_i & rx_start_i;
  assign crc_valid_o = rx_valid_i & (rx_start_i | (state_q == DATA) | (state_q == CHECK));
  assign crc_data_o  = rx_start_i ? ~rx_data_i : rx_data_i;

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign ok_o        = ok_q;
  assign fcs_err_o   = fcs_err_q;
  assign len_err_o   = len_err_q;
  assign align_err_o = align_err_q;
  assign abort_o     = abort_q;

  always_comb begin
    sow          = rx_valid_i & rx_start_i;
    eow          = rx_valid_i & rx_last_i;
    cnt_inc      = {1'b0, word_cnt_q} + 10'd1;
    // Saturated count (MAX+1) always lands above MAX, so it forces len_err.
    len_bad_cur  = (cnt_inc < MIN_W) || (cnt_inc > MAX_W);
    len_bad_one  = (10'd1 < MIN_W) || (10'd1 > MAX_W);

    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    pend_len_d   = pend_len_q;
    pend_align_d = pend_align_q;
    begin_frame  = 1'b0;
    done_d       = 1'b0;
    ok_d         = 1'b0;
    fcs_err_d    = 1'b0;
    len_err_d    = 1'b0;
    align_err_d  = 1'b0;
    abort_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sow) begin_frame = 1'b1;
      end

      DATA: begin
        if (sow) begin
          // Truncated frame: report it without an FCS compare, then restart.
          done_d      = 1'b1;
          len_err_d   = 1'b1;
          begin_frame = 1'b1;
        end else if (rx_abort_i) begin
          if (eow) begin
            done_d  = 1'b1;
            abort_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (rx_valid_i) begin
          if (cnt_inc <= SAT_W) word_cnt_d = cnt_inc[8:0];
          if (rx_last_i) begin
            state_d      = CHECK;
            pend_len_d   = len_bad_cur;
            pend_align_d = (rx_keep_i != 4'hF);
          end
        end
      end

      CHECK: begin
        // crc_i now holds the sum including the FCS word.
        done_d      = 1'b1;
        fcs_err_d   = (crc_i != RESIDUE);
        len_err_d   = pend_len_q;
        align_err_d = pend_align_q;
        ok_d        = (crc_i == RESIDUE) & ~pend_len_q & ~pend_align_q;
        state_d     = IDLE;
        // Zero-gap back-to-back: the engine restarts while crc_i is still old.
        if (sow) begin_frame = 1'b1;
      end

      DROP: begin
        if (sow) begin
          done_d      = 1'b1;
          abort_d     = 1'b1;
          begin_frame = 1'b1;
        end else if (eow) begin
          done_d  = 1'b1;
          abort_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Shared new-frame entry; a single-word frame goes straight to CHECK.
    if (begin_frame) begin
      word_cnt_d = 9'd1;
      if (rx_last_i) begin
        state_d      = CHECK;
        pend_len_d   = len_bad_one;
        pend_align_d = (rx_keep_i != 4'hF);
      end else begin
        state_d = DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      word_cnt_q   <= 9'd0;
      pend_len_q   <= 1'b0;
      pend_align_q <= 1'b0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      fcs_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      align_err_q  <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      pend_len_q   <= pend_len_d;
      pend_align_q <= pend_align_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      fcs_err_q    <= fcs_err_d;
      len_err_q    <= len_err_d;
      align_err_q  <= align_err_d;
      abort_q      <= abort_d;
    end
  end

endmodule

// File: tb/tb_mac_rx_fcs_ctrl.sv
// Bench for mac_rx_fcs_ctrl: a behavioural CRC-32 engine (MSB-first, zero
// preset, registered sum) sits on the crc_* port. Frames are built with a
// correct FCS word, expected verdicts are queued when the last word is
// driven and popped when done_o pulses.
module tb_mac_rx_fcs_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid_i, rx_start_i, rx_last_i, rx_abort_i;
  logic [3:0]  rx_keep_i;
  logic [31:0] rx_data_i;
  logic        crc_start_o, crc_valid_o;
  logic [31:0] crc_data_o;
  logic [31:0] crc_i;
  logic        busy_o, done_o, ok_o, fcs_err_o, len_err_o, align_err_o, abort_o;

  mac_rx_fcs_ctrl dut (
    .clk(clk), .reset(reset),
    .rx_valid_i(rx_valid_i), .rx_start_i(rx_start_i), .rx_last_i(rx_last_i),
    .rx_keep_i(rx_keep_i), .rx_data_i(rx_data_i), .rx_abort_i(rx_abort_i),
    .crc_start_o(crc_start_o), .crc_valid_o(crc_valid_o), .crc_data_o(crc_data_o),
    .crc_i(crc_i), .busy_o(busy_o), .done_o(done_o), .ok_o(ok_o),
    .fcs_err_o(fcs_err_o), .len_err_o(len_err_o), .align_err_o(align_err_o),
    .abort_o(abort_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ok, fcs, len, align, abort;
    int   cyc;                       // expected done cycle, -1 = not checked
  } exp_t;

  typedef struct {
    int         n;
    int         flip;
    logic [3:0] keep;
    logic       e_ok, e_fcs, e_len, e_align;
  } vec_t;

  exp_t        sbq[$];
  logic [31:0] w [0:399];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic        prev_done;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = (r << 1) ^ 32'h04C11DB7;
      else              r = r << 1;
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic ok, input logic fcs, input logic len,
                              input logic align, input logic abort);
    exp_t e;
    e.ok = ok; e.fcs = fcs; e.len = len; e.align = align; e.abort = abort; e.cyc = -1;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // CRC engine model
  always @(posedge clk) begin
    if (reset)            crc_i <= 32'h0;
    else if (crc_valid_o) crc_i <= crc_step(crc_start_o ? 32'h0 : crc_i, crc_data_o);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (done_o) begin
        check("done_single_cycle", 32'(prev_done), 0);
        if (sbq.size() == 0) begin
          check("done_unexpected", 32'(done_o), 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("ok",        32'(ok_o),        32'(e.ok));
          check("fcs_err",   32'(fcs_err_o),   32'(e.fcs));
          check("len_err",   32'(len_err_o),   32'(e.len));
          check("align_err", 32'(align_err_o), 32'(e.align));
          check("abort",     32'(abort_o),     32'(e.abort));
          if (e.cyc >= 0) check("done_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_done = done_o;
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      rx_valid_i = 0; rx_start_i = 0; rx_last_i = 0; rx_abort_i = 0;
      rx_keep_i = 4'h0; rx_data_i = 32'h0;
    end
  endtask

  // Drives an n-word frame (last word = FCS). stop_idx >= 0 stops before that
  // word without a last; abort_idx marks the word carrying rx_abort_i.
  task automatic send_frame(input int n, input int flip, input logic [3:0] keep,
                            input int abort_idx, input int stop_idx,
                            input exp_t e, input bit lat);
    logic [31:0] c;
    int          lim;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 1; i++) begin
      w[i] = $urandom;
      c = crc_step(c, w[i]);
    end
    w[n-1] = ~c;
    if (flip >= 0) w[flip][0] = ~w[flip][0];
    lim = (stop_idx >= 0) ? stop_idx : n;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      rx_valid_i = 1'b1;
      rx_start_i = (i == 0);
      rx_last_i  = (i == n - 1);
      rx_keep_i  = (i == n - 1) ? keep : 4'hF;
      rx_data_i  = w[i];
      rx_abort_i = (i == abort_idx);
      if (i == n - 1) begin
        e.cyc = lat ? cyc + 2 : -1;
        sbq.push_back(e);
      end
      if (i == 0) begin
        #1;
        check("crc_start", 32'(crc_start_o), 1);
        check("crc_data_start", crc_data_o, ~w[0]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    tbl[0] = '{n:16,  flip:-1, keep:4'hF, e_ok:1, e_fcs:0, e_len:0, e_align:0};
    tbl[1] = '{n:16,  flip:5,  keep:4'hF, e_ok:0, e_fcs:1, e_len:0, e_align:0};
    tbl[2] = '{n:10,  flip:-1, keep:4'hF, e_ok:0, e_fcs:0, e_len:1, e_align:0};
    tbl[3] = '{n:381, flip:-1, keep:4'hF, e_ok:0, e_fcs:0, e_len:1, e_align:0};
    tbl[4] = '{n:16,  flip:-1, keep:4'h7, e_ok:0, e_fcs:0, e_len:0, e_align:1};

    reset = 1; rx_valid_i = 0; rx_start_i = 0; rx_last_i = 0; rx_abort_i = 0;
    rx_keep_i = 4'h0; rx_data_i = 32'h0; prev_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_flags", {26'd0, done_o, ok_o, fcs_err_o, len_err_o, align_err_o, abort_o}, 0);

    // Word without start in IDLE is dropped silently
    @(posedge clk); #1;
    rx_valid_i = 1; rx_data_i = 32'h1234_5678;
    @(negedge clk);
    check("idle_nostart_crc_valid", 32'(crc_valid_o), 0);
    idle(1);
    @(negedge clk);
    check("idle_nostart_busy", 32'(busy_o), 0);

    // Table-driven single frames
    for (int k = 0; k < 5; k++) begin
      send_frame(tbl[k].n, tbl[k].flip, tbl[k].keep, -1, -1,
                 mk(tbl[k].e_ok, tbl[k].e_fcs, tbl[k].e_len, tbl[k].e_align, 1'b0), 1'b1);
      idle(4);
    end

    // Zero-gap back-to-back good frames (second start lands in CHECK)
    send_frame(16, -1, 4'hF, -1, -1, mk(1, 0, 0, 0, 0), 1'b1);
    send_frame(16, -1, 4'hF, -1, -1, mk(1, 0, 0, 0, 0), 1'b1);
    idle(4);

    // Truncated frame: new start in DATA, then a good frame
    send_frame(16, -1, 4'hF, -1, 5, mk(0, 0, 0, 0, 0), 1'b0);
    sbq.push_back(mk(0, 0, 1, 0, 0));
    send_frame(16, -1, 4'hF, -1, -1, mk(1, 0, 0, 0, 0), 1'b1);
    idle(4);

    // Abort at word 3
    send_frame(16, -1, 4'hF, 2, -1, mk(0, 0, 0, 0, 1), 1'b0);
    idle(4);

    // Reset at word 8 of the next frame: no result, outputs cleared
    send_frame(16, -1, 4'hF, -1, 8, mk(0, 0, 0, 0, 0), 1'b0);
    @(posedge clk); #1;
    reset = 1; rx_valid_i = 0; rx_start_i = 0; rx_last_i = 0; rx_abort_i = 0;
    rx_keep_i = 4'h0; rx_data_i = 32'h0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("post_rst_outputs",
          {23'd0, busy_o, done_o, ok_o, fcs_err_o, len_err_o, align_err_o, abort_o,
           crc_start_o, crc_valid_o}, 0);
    check("post_rst_crc_data", crc_data_o, 0);
    idle(6);
    check("post_rst_no_result", 32'(sbq.size()), 0);

    // First frame after reset is processed normally
    send_frame(16, -1, 4'hF, -1, -1, mk(1, 0, 0, 0, 0), 1'b1);
    idle(2);

    for (int t = 0; t < 50 && sbq.size() != 0; t++) @(posedge clk);
    idle(2);
    check("scoreboard_drain", 32'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_rx_fcs_ctrl.md
MAC_RX_FCS_CTRL -- requirements
Module: mac_rx_fcs_ctrl

Interface
REQ-001 The block SHALL have the parameter MIN_WORDS, default 16, giving the minimum frame length in 32-bit words, FCS included.
REQ-002 The block SHALL have the parameter MAX_WORDS, default 380, giving the maximum frame length in words, FCS included.
REQ-003 The block SHALL have the parameter RESIDUE, default 32'hC704DD7B, giving the CRC engine value that indicates a good FCS.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rx_valid_i  in  1  input word valid
- rx_start_i  in  1  first word of frame, qualified by rx_valid_i
- rx_last_i  in  1  last word of frame, qualified by rx_valid_i
- rx_keep_i  in  4  byte enables of the last word; LSB is byte 0
- rx_data_i  in  32  frame word, FCS included
- rx_abort_i  in  1  PCS error or abort for the current frame
- crc_start_o  out  1  CRC engine start
- crc_valid_o  out  1  CRC engine valid
- crc_data_o  out  32  CRC engine data
- crc_i  in  32  registered CRC engine sum
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle frame-result pulse
- ok_o  out  1  frame good, valid with done_o
- fcs_err_o, len_err_o, align_err_o, abort_o  out  1 each  error causes, valid with done_o

Function
REQ-005 The block SHALL implement an FSM with the states IDLE, DATA, CHECK and DROP.
REQ-006 The crc_* outputs SHALL be combinational from the rx_* inputs, as follows:
- crc_valid_o = rx_valid_i, gated off in DROP and in IDLE without rx_start_i;
- crc_start_o = rx_valid_i & rx_start_i;
- crc_data_o = ~rx_data_i on the start word and rx_data_i otherwise (all-ones preset over the engine's zero preset).
REQ-007 In IDLE, rx_valid_i & rx_start_i SHALL load word_cnt=1 and go to DATA; if rx_last_i is also high, the block SHALL go directly to CHECK.
REQ-008 In DATA, each rx_valid_i SHALL increment word_cnt, saturating at MAX_WORDS+1; cycles with rx_valid_i low SHALL hold all state.
REQ-009 In DATA, rx_valid_i & rx_last_i SHALL go to CHECK and latch the flags:
- align_err = (rx_keep_i != 4'hF);
- len_err = (word_cnt+1 < MIN_WORDS) or (word_cnt+1 > MAX_WORDS).
REQ-010 CHECK SHALL last exactly one cycle, in which:
- fcs_err = (crc_i != RESIDUE);
- the done_o, ok_o and error registers load, so done_o is high in the following cycle;
- the state returns to IDLE.
REQ-011 Latency: with the last word accepted in cycle N, crc_i is final in N+1 and done_o SHALL pulse in N+2.
REQ-012 ok_o SHALL be 1 only when fcs_err, len_err, align_err and abort are all 0.
REQ-013 rx_start_i with rx_valid_i in CHECK SHALL be accepted as a new frame per REQ-007 (zero-gap back-to-back), because the engine restarts while crc_i still holds the old sum.
REQ-014 rx_start_i with rx_valid_i in DATA (truncated frame) SHALL end the old frame with done_o, len_err_o=1, ok_o=0 and no FCS compare, and SHALL restart at word_cnt=1 in DATA.
REQ-015 rx_abort_i in DATA SHALL go to DROP.
REQ-016 In DROP:
- words SHALL be discarded until rx_valid_i & rx_last_i, which then SHALL produce done_o with abort_o=1, ok_o=0 and no FCS compare;
- rx_start_i with rx_valid_i SHALL end the aborted frame as in the previous bullet and begin the new frame per REQ-014.
REQ-017 rx_abort_i in IDLE or CHECK SHALL be ignored.
REQ-018 word_cnt SHALL be 9 bits and reaching saturation SHALL force len_err.
REQ-019 busy_o SHALL be high in DATA, CHECK and DROP.
REQ-020 Words without rx_start_i in IDLE SHALL be discarded silently, with crc_valid_o low.
REQ-021 done_o SHALL never be high for more than one consecutive cycle per frame.

Reset
REQ-022 On reset, the block SHALL go to IDLE with word_cnt=0, and the flag registers done_o, ok_o, fcs_err_o, len_err_o, align_err_o and abort_o SHALL all be 0.
REQ-023 Reset asserted mid-frame SHALL discard the frame without a done_o pulse.
REQ-024 The first frame after reset release SHALL be processed normally.

Verification
REQ-025 The bench SHALL cover: a 16-word frame with valid FCS and keep=4'hF -> done_o two cycles after the last word, ok_o=1, all error flags 0.
REQ-026 The bench SHALL cover: the same frame with data bit 0 of word 5 flipped -> fcs_err_o=1, ok_o=0.
REQ-027 The bench SHALL cover: a 10-word frame, and separately a 381-word frame -> len_err_o=1 in both cases.
REQ-028 The bench SHALL cover: a last word with keep=4'h7 -> align_err_o=1, ok_o=0.
REQ-029 The bench SHALL cover: two good frames with zero gap, the second start in the CHECK cycle of the first -> two done_o pulses, both ok_o=1.
REQ-030 The bench SHALL cover: rx_abort_i at word 3, then reset at word 8 of a later frame -> the first frame gives abort_o=1; the second gives no done_o, and all outputs are 0 in the cycle after reset.
